// File: rtl/credit_sender.sv
// credit_sender
//
// Credit-based flow-control sender. It sits between an upstream producer and
// a downstream FIFO of depth CREDITS. It keeps a count of free FIFO entries
// and only accepts a word from the producer while that count is non-zero.
// The FIFO read logic returns one credit per word it consumes, and that
// return travels through RETURN_LATENCY register stages before it reaches
// the counter.
//
// Handshake (upstream side): i_valid/o_ready follow strict valid/ready
// semantics. A word transfers in exactly the cycles where i_valid && o_ready
// are both high. o_ready depends only on the credit register, never on
// i_valid. While i_valid is high and o_ready is low, the producer must hold
// i_data stable. The downstream side has no ready: o_valid is a write enable.
//
// Ports
//   clock              single clock, rising edge
//   reset              synchronous, active-low
//   i_data, i_valid    upstream payload and its valid
//   o_ready            a credit is available (count != 0)
//   o_data, o_valid    registered payload and write enable toward the FIFO
//   i_increment_count  one-cycle credit-return pulse from FIFO read logic
//   o_credit_count     registered credit count
//   o_overflow         sticky: a credit returned while the count was full

module credit_sender #(
    parameter int DATA_WIDTH     = 16,
    parameter int CREDITS        = 8,
    parameter int RETURN_LATENCY = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          i_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_valid,
    input  logic                           i_increment_count,
    output logic [$clog2(CREDITS+1)-1:0]   o_credit_count,
    output logic                           o_overflow
);

    localparam int COUNT_W = $clog2(CREDITS + 1);
    localparam logic [COUNT_W-1:0] CREDITS_C = COUNT_W'(CREDITS);

    logic                  ret;
    logic                  send;
    logic [COUNT_W-1:0]    count_q,    count_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic                  valid_q,    valid_d;
    logic                  overflow_q, overflow_d;

    // Credit-return path: RETURN_LATENCY flops, or a straight wire when zero.
    // The stages clear on reset so returns in flight are dropped.
    if (RETURN_LATENCY == 0) begin : g_ret_direct
        assign ret = i_increment_count;
    end else begin : g_ret_pipe
        logic [RETURN_LATENCY-1:0] ret_pipe_q, ret_pipe_d;

        always_comb begin
            ret_pipe_d    = ret_pipe_q << 1;
            ret_pipe_d[0] = i_increment_count;
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                ret_pipe_q <= '0;
            end else begin
                ret_pipe_q <= ret_pipe_d;
            end
        end

        assign ret = ret_pipe_q[RETURN_LATENCY-1];
    end

    // Ready comes from the count register alone, so no send can happen at
    // zero credits and the counter cannot underflow.
    assign o_ready = (count_q != '0);
    assign send    = i_valid && o_ready;

    always_comb begin
        count_d    = count_q;
        data_d     = data_q;
        valid_d    = send;
        overflow_d = overflow_q;

        if (send) begin
            data_d = i_data;
        end

        if (send && !ret) begin
            count_d = count_q - COUNT_W'(1);
        end else if (!send && ret) begin
            // A return with no matching send while already full means the
            // downstream returned more credits than it was given.
            if (count_q == CREDITS_C) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + COUNT_W'(1);
            end
        end
        // send && ret cancel out, including at a full count.
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q    <= CREDITS_C;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_data         = data_q;
    assign o_valid        = valid_q;
    assign o_credit_count = count_q;
    assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender: a table of per-cycle vectors on the default
// instance (CREDITS=8, RETURN_LATENCY=2), hand-written sequences for reset
// with returns in flight, and a second instance with RETURN_LATENCY=0.

module tb_credit_sender;

  localparam int DW = 16;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // main instance: CREDITS=8, RETURN_LATENCY=2
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          i_increment_count;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic [3:0]    o_credit_count;
  logic          o_overflow;

  credit_sender #(.DATA_WIDTH(DW), .CREDITS(8), .RETURN_LATENCY(2)) dut (
    .clock             (clock),
    .reset             (reset),
    .i_data            (i_data),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .o_data            (o_data),
    .o_valid           (o_valid),
    .i_increment_count (i_increment_count),
    .o_credit_count    (o_credit_count),
    .o_overflow        (o_overflow)
  );

  // second instance: CREDITS=2, RETURN_LATENCY=0
  logic [DW-1:0] z_i_data;
  logic          z_i_valid;
  logic          z_i_inc;
  logic          z_o_ready;
  logic [DW-1:0] z_o_data;
  logic          z_o_valid;
  logic [1:0]    z_o_count;
  logic          z_o_overflow;

  credit_sender #(.DATA_WIDTH(DW), .CREDITS(2), .RETURN_LATENCY(0)) dut_z (
    .clock             (clock),
    .reset             (reset),
    .i_data            (z_i_data),
    .i_valid           (z_i_valid),
    .o_ready           (z_o_ready),
    .o_data            (z_o_data),
    .o_valid           (z_o_valid),
    .i_increment_count (z_i_inc),
    .o_credit_count    (z_o_count),
    .o_overflow        (z_o_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: words expected on the main instance's write port, in order
  logic [DW-1:0] exp_q[$];
  logic          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && o_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got write %0h expected none", o_data);
      end else begin
        check("sb_data", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // vector table
  typedef struct {
    int valid;
    int data;
    int inc;
    int exp_valid;
    int exp_data;
    int exp_count;
    int exp_ready;
    int exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int v, input int d, input int inc, input int ev,
                     input int ed, input int ec, input int er, input int eo);
    vec_t t;
    t.valid = v; t.data = d; t.inc = inc; t.exp_valid = ev;
    t.exp_data = ed; t.exp_count = ec; t.exp_ready = er; t.exp_ovf = eo;
    vecs.push_back(t);
  endtask

  // driver tasks: drive after the edge, sample #1 after the next edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic inc);
    i_valid = v;
    i_data = d;
    i_increment_count = inc;
    @(posedge clock);
    #1;
  endtask

  task automatic step_z(input logic v, input logic [DW-1:0] d, input logic inc);
    z_i_valid = v;
    z_i_data = d;
    z_i_inc = inc;
    @(posedge clock);
    #1;
  endtask

  task automatic check_main(input string tag, input int c, input int r, input int o);
    check({tag, "_count"}, 32'(o_credit_count), 32'(c));
    check({tag, "_ready"}, 32'(o_ready), 32'(r));
    check({tag, "_ovf"}, 32'(o_overflow), 32'(o));
  endtask

  task automatic check_z(input string tag, input int v, input int d, input int c,
                         input int r, input int o);
    check({tag, "_valid"}, 32'(z_o_valid), 32'(v));
    check({tag, "_data"}, 32'(z_o_data), 32'(d));
    check({tag, "_count"}, 32'(z_o_count), 32'(c));
    check({tag, "_ready"}, 32'(z_o_ready), 32'(r));
    check({tag, "_ovf"}, 32'(z_o_overflow), 32'(o));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // burst of 10 with data 1..10, 8 credits
    for (int k = 1; k <= 8; k++) add(1, k, 0, 1, k, 8 - k, (k < 8) ? 1 : 0, 0);
    add(1, 9, 0, 0, 8, 0, 0, 0);
    add(1, 10, 0, 0, 8, 0, 0, 0);
    // one return at T, producer holds word 9
    add(1, 9, 1, 0, 8, 0, 0, 0);
    add(1, 9, 0, 0, 8, 0, 0, 0);
    add(1, 9, 0, 0, 8, 1, 1, 0);
    add(1, 9, 0, 1, 9, 0, 0, 0);
    // four returns to reach count 4
    add(0, 0, 1, 0, 9, 0, 0, 0);
    add(0, 0, 1, 0, 9, 0, 0, 0);
    add(0, 0, 1, 0, 9, 1, 1, 0);
    add(0, 0, 1, 0, 9, 2, 1, 0);
    add(0, 0, 0, 0, 9, 3, 1, 0);
    add(0, 0, 0, 0, 9, 4, 1, 0);
    // send coinciding with a delayed return at count 4
    add(0, 0, 1, 0, 9, 4, 1, 0);
    add(0, 0, 0, 0, 9, 4, 1, 0);
    add(1, 'ha5a5, 0, 1, 'ha5a5, 4, 1, 0);
    // refill to 8
    add(0, 0, 1, 0, 'ha5a5, 4, 1, 0);
    add(0, 0, 1, 0, 'ha5a5, 4, 1, 0);
    add(0, 0, 1, 0, 'ha5a5, 5, 1, 0);
    add(0, 0, 1, 0, 'ha5a5, 6, 1, 0);
    add(0, 0, 0, 0, 'ha5a5, 7, 1, 0);
    add(0, 0, 0, 0, 'ha5a5, 8, 1, 0);
    // send and return together at full count: legal, no overflow
    add(0, 0, 1, 0, 'ha5a5, 8, 1, 0);
    add(0, 0, 0, 0, 'ha5a5, 8, 1, 0);
    add(1, 'h1234, 0, 1, 'h1234, 8, 1, 0);
    // return with no send at full count: overflow, sticky
    add(0, 0, 1, 0, 'h1234, 8, 1, 0);
    add(0, 0, 0, 0, 'h1234, 8, 1, 0);
    add(0, 0, 0, 0, 'h1234, 8, 1, 1);
    add(0, 0, 0, 0, 'h1234, 8, 1, 1);
    add(1, 'h0bee, 0, 1, 'h0bee, 7, 1, 1);

    // reset with inputs active; they must be ignored
    reset = 1'b0;
    i_valid = 1'b1; i_data = 16'hdead; i_increment_count = 1'b1;
    z_i_valid = 1'b1; z_i_data = 16'hbeef; z_i_inc = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check_main("rst", 8, 1, 0);
    reset = 1'b1;
    i_valid = 1'b0; i_data = '0; i_increment_count = 1'b0;
    z_i_valid = 1'b0; z_i_data = '0; z_i_inc = 1'b0;
    #1;
    check("post_rst_ready", 32'(o_ready), 32'd1);
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].exp_valid != 0) exp_q.push_back(DW'(vecs[i].exp_data));
      step(vecs[i].valid[0], DW'(vecs[i].data), vecs[i].inc[0]);
      check($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_data", i), 32'(o_data), 32'(vecs[i].exp_data));
      check_main($sformatf("v%0d", i), vecs[i].exp_count, vecs[i].exp_ready, vecs[i].exp_ovf);
    end

    // count 7 -> 3, then two returns in flight, then a one-cycle reset
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(DW'(16'h21 + k));
      step(1'b1, DW'(16'h21 + k), 1'b0);
      check_main($sformatf("drain%0d", k), 6 - k, 1, 1);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check_main("inflight", 3, 1, 1);
    reset = 1'b0;
    step(1'b0, '0, 1'b0);
    check("rst2_valid", 32'(o_valid), 32'd0);
    check("rst2_data", 32'(o_data), 32'd0);
    check_main("rst2", 8, 1, 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b0);
      check_main($sformatf("discard%0d", k), 8, 1, 0);
    end

    // zero-latency instance, 2 credits
    check_z("z_init", 0, 0, 2, 1, 0);
    step_z(1'b1, 16'h0055, 1'b0);
    check_z("z_send1", 1, 'h55, 1, 1, 0);
    step_z(1'b1, 16'h0066, 1'b0);
    check_z("z_send2", 1, 'h66, 0, 0, 0);
    step_z(1'b1, 16'h0077, 1'b1);
    check_z("z_ret", 0, 'h66, 1, 1, 0);
    step_z(1'b1, 16'h0077, 1'b1);
    check_z("z_both", 1, 'h77, 1, 1, 0);
    step_z(1'b0, 16'h0000, 1'b1);
    check_z("z_fill", 0, 'h77, 2, 1, 0);
    step_z(1'b0, 16'h0000, 1'b1);
    check_z("z_ovf", 0, 'h77, 2, 1, 1);
    step_z(1'b0, 16'h0000, 1'b0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/credit_sender.md
CREDIT_SENDER -- requirements
Module: credit_sender

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the payload width in bits.
REQ-002 Parameter CREDITS, default 8, SHALL equal the downstream FIFO depth and the initial credit count; legal range 1..255.
REQ-003 Parameter RETURN_LATENCY, default 2, SHALL set the register stages on the credit-return path; legal range 0..4.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-006 i_data  input  DATA_WIDTH  SHALL carry the payload from the upstream producer.
REQ-007 i_valid  input  1  SHALL indicate i_data is valid this cycle.
REQ-008 o_ready  output  1  SHALL indicate a credit is available and an offered word will be accepted.
REQ-009 o_data  output  DATA_WIDTH  SHALL carry the payload toward the downstream FIFO write port.
REQ-010 o_valid  output  1  SHALL act as the downstream FIFO write enable.
REQ-011 i_increment_count  input  1  SHALL be the one-cycle credit-return pulse from the downstream FIFO read logic.
REQ-012 o_credit_count  output  $clog2(CREDITS+1)  SHALL expose the current credit count.
REQ-013 o_overflow  output  1  SHALL be a sticky flag for a credit return received while the count is already CREDITS.

Function
REQ-014 o_ready SHALL be 1 iff credit count != 0, driven combinationally from the count register only; it SHALL NOT depend on i_valid.
REQ-015 A send SHALL occur in a cycle where i_valid && o_ready.
REQ-016 On a send, o_data SHALL take i_data and o_valid SHALL be 1 at the next edge; latency exactly 1 cycle.
REQ-017 In a cycle with no send, o_valid SHALL be 0 at the next edge and o_data SHALL hold its value.
REQ-018 i_valid while o_ready=0 SHALL be ignored: no write, no count change; the producer holds the word.
REQ-019 i_increment_count SHALL pass through exactly RETURN_LATENCY registers to form ret; with RETURN_LATENCY=0, ret = i_increment_count combinationally.
REQ-020 Count update: send only -> count-1; ret only -> count+1; send and ret in the same cycle -> unchanged; neither -> unchanged.
REQ-021 Count SHALL never underflow; REQ-014 guarantees no send at count 0.
REQ-022 When ret=1, no send and count=CREDITS: count SHALL stay at CREDITS and o_overflow SHALL set.
REQ-023 When ret=1, a send and count=CREDITS: this SHALL be a legal simultaneous event; count stays CREDITS and o_overflow is not set.
REQ-024 o_overflow SHALL remain 1 until reset.
REQ-025 Back-to-back sends SHALL be supported: sustained throughput of 1 word per cycle while credits remain.
REQ-026 o_credit_count SHALL reflect the registered count, updated one edge after the causing event.

Reset
REQ-027 On a clock edge with reset=0: count = CREDITS, o_valid = 0, o_data = 0, o_overflow = 0, and all return-path registers = 0.
REQ-028 Returns in flight in the pipeline when reset is asserted SHALL be discarded.
REQ-029 During reset, i_valid and i_increment_count SHALL be ignored. o_ready SHALL follow REQ-014 from the reset count, i.e. it is 1 in the first cycle after reset deasserts.

Verification
REQ-030 CREDITS=8, RETURN_LATENCY=2, no returns, i_valid=1 for 10 cycles with data 1..10:
  - exactly words 1..8 appear on o_data with o_valid=1 on consecutive cycles;
  - o_ready=0 after the 8th send;
  - o_credit_count=0.
REQ-031 From count 0, one i_increment_count pulse at cycle T:
  - o_credit_count=1 after the edge at T+2;
  - o_ready=1 in cycle T+3;
  - the held word 9 is then sent and count returns to 0.
REQ-032 Count 4; send and a delayed return in the same cycle -> count stays 4, o_valid=1 next cycle.
REQ-033 Count 8, idle; one return pulse -> count stays 8, o_overflow=1 and stays 1 until reset.
REQ-034 Count 3; two return pulses in the pipeline; reset asserted for 1 cycle -> count=8, o_overflow=0, o_valid=0, and no later count increment from the discarded pulses.
REQ-035 RETURN_LATENCY=0, count 0; i_increment_count=1 in cycle T -> count=1 after that edge, o_ready=1 in cycle T+1.
